mul_div_seq: RTL
================

MUL_DIV_SEQ -- requirements
Module: mul_div_seq

Interface
REQ-001 SHALL have parameter W, default 16: operand/result width in bits, even, >= 4.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request; accepted only in IDLE.
REQ-005 SHALL have port op  input  2  operation: 00 MUL, 01 DIV, 10 MOD, 11 reserved (treated as MUL).
REQ-006 SHALL have port sgn  input  1  signed mode (MLI/DVI/MDI) when 1.
REQ-007 SHALL have port b  input  W  first operand (multiplicand / dividend).
REQ-008 SHALL have port a  input  W  second operand (multiplier / divisor).
REQ-009 SHALL have port busy  output  1  high while an accepted operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when q/ex are updated.
REQ-011 SHALL have port q  output  W  primary result.
REQ-012 SHALL have port ex  output  W  overflow/extension result.

Function
REQ-013 SHALL implement states IDLE, CALC, FIN; busy = (state != IDLE).
REQ-014 SHALL, at an edge with start=1 in IDLE, latch op, sgn, a, b and iteration count N (MUL: W, DIV: 2W, MOD: W), then enter CALC; start in CALC/FIN SHALL be ignored.
REQ-015 SHALL, when sgn=1, operate on magnitudes |b|, |a| (MSB set => two's-complement negate, W-bit unsigned result; most-negative value maps to 2^(W-1)).
REQ-016 SHALL compute MUL by one shift-add step per CALC edge, producing the 2W-bit unsigned product P.
REQ-017 SHALL compute DIV by one restoring-division step per CALC edge on dividend {b_mag, W zeros}, producing 2W-bit quotient D.
REQ-018 SHALL compute MOD by one restoring-division step per CALC edge on b_mag, producing W-bit remainder R.
REQ-019 SHALL leave CALC for FIN at the edge performing step N.
REQ-020 SHALL, for DIV/MOD with a==0 at acceptance, set N=0 and go IDLE -> FIN directly, skipping CALC.
REQ-021 SHALL, at the FIN edge, register results, pulse done=1 for exactly one cycle and return to IDLE.
REQ-022 SHALL set MUL results to {ex,q} = P, negated (2W-bit) when sgn=1 and sign(a) != sign(b).
REQ-023 SHALL set DIV results to {q,ex} = D, negated (2W-bit) when sgn=1 and signs differ; divisor 0 gives q=0, ex=0.
REQ-024 SHALL set MOD results to q = R, negated when sgn=1 and b negative, and ex=0; divisor 0 gives q=0, ex=0.
REQ-025 SHALL, counting the accepting edge as edge 0, raise done after edge N+1 (MUL/MOD: W+1, DIV: 2W+1, divide-by-zero: 1) and keep busy high from edge 0 through edge N+1.
REQ-026 SHALL hold q/ex stable from a done pulse until the next FIN edge; operand changes after acceptance SHALL have no effect.
REQ-027 SHALL accept start asserted in the done cycle (state is IDLE), giving back-to-back operations.

Reset
REQ-028 SHALL, on any edge with rst=1, force IDLE, busy=0, done=0, q=0, ex=0 and clear all datapath registers; rst SHALL override start.
REQ-029 SHALL, on rst mid-operation, abort without any done pulse; a start on the first edge after rst deasserts SHALL be accepted.

Verification (W=16)
REQ-030 SHALL cover: MUL sgn=0 b=0x1234 a=0x0010 -> done after edge 17, q=0x2340, ex=0x0001; then MLI b=0xFFFE a=0x0003 -> q=0xFFFA, ex=0xFFFF.
REQ-031 SHALL cover: DIV sgn=0 b=7 a=2 -> done after edge 33, q=0x0003, ex=0x8000; DVI b=0xFFF8 a=0x0002 -> q=0xFFFC, ex=0x0000; DVI b=0x8000 a=0xFFFF -> q=0x8000, ex=0x0000.
REQ-032 SHALL cover: MOD sgn=0 b=17 a=5 -> q=0x0002, ex=0; MDI b=0xFFF9 a=0x0002 -> q=0xFFFF; MDI b=0x0007 a=0xFFFE -> q=0x0001.
REQ-033 SHALL cover: DIV b=5 a=0 and MOD b=5 a=0 -> done after edge 1, q=0, ex=0.
REQ-034 SHALL cover: start held high, a/b changed during busy -> single result from the latched operands; new start in the done cycle accepted, busy stays high with no IDLE gap.
REQ-035 SHALL cover: rst asserted at edge 10 of a DIV -> busy=0, q=0, ex=0 next cycle, no done pulse; following MUL 3*4 -> q=0x000C, ex=0.

Source files
------------

// File: rtl/mul_div_seq.sv
// Sequential multiplier / divider: shift-add MUL, restoring DIV (2W-bit quotient) and MOD,
// signed or unsigned, one datapath step per clock.
module mul_div_seq #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic         sgn,
  input  logic [W-1:0] b,
  input  logic [W-1:0] a,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] q,
  output logic [W-1:0] ex
);

  localparam int unsigned CW = $clog2(2 * W + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  typedef enum logic [1:0] {K_MUL, K_DIV, K_MOD} kind_t;

  state_t          state;
  kind_t           kind;
  logic            neg_res;
  logic            neg_rem;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  acc;
  logic [W-1:0]    opnd;
  logic [W-1:0]    rem;

  kind_t           kind_in;
  logic [W-1:0]    a_mag;
  logic [W-1:0]    b_mag;
  logic            a_zero;
  logic [W:0]      mul_sum;
  logic [W:0]      rem_sh;
  logic [W:0]      diff;
  logic            ge;
  logic [2*W-1:0]  acc_neg;
  logic [W-1:0]    rem_neg;

  assign busy = (state != IDLE);

  // Operand decode and magnitudes at acceptance
  always_comb begin
    kind_in = K_MUL;
    if (op == 2'b01) kind_in = K_DIV;
    else if (op == 2'b10) kind_in = K_MOD;
    a_mag  = (sgn && a[W-1]) ? ('0 - a) : a;
    b_mag  = (sgn && b[W-1]) ? ('0 - b) : b;
    a_zero = (a == '0);
  end

  // One shift-add step (acc = {partial, multiplier}) and one restoring-division step
  always_comb begin
    mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    rem_sh  = {rem, acc[2*W-1]};
    diff    = rem_sh - {1'b0, opnd};
    ge      = ~diff[W];
    acc_neg = '0 - acc;
    rem_neg = '0 - rem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      kind    <= K_MUL;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      rem     <= '0;
      done    <= 1'b0;
      q       <= '0;
      ex      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            kind    <= kind_in;
            neg_res <= sgn & (a[W-1] ^ b[W-1]);
            neg_rem <= sgn & b[W-1];
            rem     <= '0;
            if (kind_in == K_MUL) begin
              acc   <= {{W{1'b0}}, a_mag};
              opnd  <= b_mag;
              cnt   <= CW'(W);
              state <= CALC;
            end else if (a_zero) begin
              // Divide by zero: cleared datapath yields q=0, ex=0 at FIN
              acc   <= '0;
              opnd  <= '0;
              cnt   <= '0;
              state <= FIN;
            end else begin
              acc   <= {b_mag, {W{1'b0}}};
              opnd  <= a_mag;
              cnt   <= (kind_in == K_DIV) ? CW'(2 * W) : CW'(W);
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (kind == K_MUL) begin
            acc <= {mul_sum, acc[W-1:1]};
          end else begin
            acc <= {acc[2*W-2:0], ge};
            rem <= ge ? diff[W-1:0] : rem_sh[W-1:0];
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIN;
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
          case (kind)
            K_MUL: {ex, q} <= neg_res ? acc_neg : acc;
            K_DIV: {q, ex} <= neg_res ? acc_neg : acc;
            default: begin
              q  <= neg_rem ? rem_neg : rem;
              ex <= '0;
            end
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
